note_tone_generator: RTL and testbench

NOTE_TONE_GENERATOR -- requirements
Module: note_tone_generator

---
 rtl/note_tone_generator_pkg.sv | 15 +
 rtl/note_tone_generator_ms_timebase.sv | 30 +++
 rtl/note_tone_generator.sv | 124 ++++++++++++
 tb/tb_note_tone_generator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_tone_generator_pkg.sv
// Shared types and defaults for the note player and the music sequencer built on it.
// Holds the player state encoding and the default gap length / duration field width.
package note_tone_generator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int GAP_MS_DEFAULT = 10;
  localparam int DUR_W_DEFAULT  = 12;
  localparam int TICK_W         = 16;

endpackage

// File: rtl/note_tone_generator_ms_timebase.sv
// Millisecond timebase: strobes on the last clk cycle of every ms; clear restarts the ms.
// Latency: strobe is combinational from the tick count; no backpressure.
module ms_timebase
  import note_tone_generator_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [TICK_W-1:0] ticks_per_milli,
  output logic              ms_strobe
);

  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_last;

  // A programmed value of 0 behaves as 1 tick per ms.
  assign tick_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - {{(TICK_W-1){1'b0}}, 1'b1};
  assign ms_strobe = (tick_cnt == tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clear || ms_strobe) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + {{(TICK_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/note_tone_generator.sv
// Plays one square-wave note for duration ms, then a silent GAP_MS gap, then pulses note_done.
// Tone starts the cycle after accept; note_ready is low outside IDLE or while stop is high.
module note_tone_generator
  import note_tone_generator_pkg::*;
#(
  parameter int GAP_MS = GAP_MS_DEFAULT,
  parameter int DUR_W  = DUR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] ticks_per_milli,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [TICK_W-1:0] note_half_period,
  input  logic [DUR_W-1:0]  note_duration,
  input  logic              stop,
  output logic              sound,
  output logic              note_active,
  output logic              note_done
);

  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [MS_W:0] GAP_TGT = (MS_W + 1)'(GAP_MS);

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] half_q;
  logic [DUR_W-1:0]  dur_q;
  logic [TICK_W-1:0] tone_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [MS_W:0]     ms_cnt_inc;
  logic [MS_W:0]     ms_tgt;
  logic              ms_strobe;
  logic              ms_last;
  logic              gap_done;
  logic              tb_clear;
  logic              accept;
  logic              done_nxt;

  assign note_ready  = (state == S_IDLE) & ~stop;
  assign accept      = note_valid & note_ready;
  assign note_active = (state == S_PLAY);

  // Duration is tracked by counting ms strobes against the target for the current state.
  assign ms_tgt     = (state == S_PLAY) ? {{(MS_W - DUR_W + 1){1'b0}}, dur_q} : GAP_TGT;
  assign ms_cnt_inc = {1'b0, ms_cnt} + {{MS_W{1'b0}}, 1'b1};
  assign ms_last    = ms_strobe & (ms_cnt_inc == ms_tgt);
  assign gap_done   = (GAP_MS == 0) ? 1'b1 : ms_last;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nxt = (note_duration != '0) ? S_PLAY : S_GAP;
      S_PLAY: if (ms_last) state_nxt = S_GAP;
      S_GAP: begin
        if (gap_done) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (stop) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end
  end

  // Timebase restarts on every state entry and is held idle in IDLE.
  assign tb_clear = (state_nxt != state) | (state == S_IDLE);

  ms_timebase u_ms_timebase (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (tb_clear),
    .ticks_per_milli (ticks_per_milli),
    .ms_strobe       (ms_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      note_done <= 1'b0;
      half_q    <= '0;
      dur_q     <= '0;
      ms_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      note_done <= done_nxt;
      if (accept) begin
        half_q <= note_half_period;
        dur_q  <= note_duration;
      end
      if (tb_clear) begin
        ms_cnt <= '0;
      end else if (ms_strobe) begin
        ms_cnt <= ms_cnt_inc[MS_W-1:0];
      end
    end
  end

  // Tone only runs while staying in PLAY, so it starts low on entry and is low everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sound    <= 1'b0;
      tone_cnt <= '0;
    end else if ((state == S_PLAY) && (state_nxt == S_PLAY)) begin
      if (half_q != '0) begin
        if (tone_cnt == half_q - {{(TICK_W-1){1'b0}}, 1'b1}) begin
          sound    <= ~sound;
          tone_cnt <= '0;
        end else begin
          tone_cnt <= tone_cnt + {{(TICK_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      sound    <= 1'b0;
      tone_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: note-level timing model checked every cycle, plus directed
// literal expectations for latency, PLAY length, tone edges, stop and reset behaviour.
module tb_note_tone_generator;

  localparam int GAP = 10;
  localparam int DW  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   ticks_per_milli = '0;
  logic          note_valid = 1'b0;
  logic          note_ready;
  logic [15:0]   note_half_period = '0;
  logic [DW-1:0] note_duration = '0;
  logic          stop = 1'b0;
  logic          sound;
  logic          note_active;
  logic          note_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_tone_generator #(.GAP_MS(GAP), .DUR_W(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ticks_per_milli  (ticks_per_milli),
    .note_valid       (note_valid),
    .note_ready       (note_ready),
    .note_half_period (note_half_period),
    .note_duration    (note_duration),
    .stop             (stop),
    .sound            (sound),
    .note_active      (note_active),
    .note_done        (note_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Note-level model: a note occupies elapsed cycles 0..end-1 after its accept edge.
  int cyc = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_e = 0, m_h = 0, m_t = 1, m_play = 0, m_end = 0;
  int n_acc = 0, acc_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (stop) m_busy = 1'b0;
        else begin
          m_e++;
          if (m_e == m_end) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (note_valid && !stop) begin
        m_busy  = 1'b1;
        m_e     = 0;
        m_h     = int'(note_half_period);
        m_t     = (ticks_per_milli == 16'd0) ? 1 : int'(ticks_per_milli);
        m_play  = int'(note_duration) * m_t;
        m_end   = m_play + ((GAP == 0) ? 1 : GAP * m_t);
        n_acc++;
        acc_cyc = cyc;
      end
    end
  end

  int act_cnt = 0, rises = 0, done_cnt = 0, done_at = 0;
  bit snd_prev = 1'b0;
  bit e_act, e_snd, e_rdy;

  always @(negedge clk) begin
    if (rst_n) begin
      e_act = m_busy && (m_e < m_play);
      e_snd = e_act && (m_h != 0) && (((m_e / ((m_h == 0) ? 1 : m_h)) % 2) == 1);
      e_rdy = !m_busy && !stop;
      chk("note_ready", 32'(note_ready), 32'(e_rdy));
      chk("note_active", 32'(note_active), 32'(e_act));
      chk("sound", 32'(sound), 32'(e_snd));
      chk("note_done", 32'(note_done), 32'(m_done));
      if (note_active === 1'b1) act_cnt++;
      if (sound === 1'b1 && !snd_prev) rises++;
      if (note_done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      snd_prev = (sound === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input string tag, input int n0);
    int k = 0;
    while (n_acc == n0 && k < 50) begin
      step(1);
      k++;
    end
    chk({tag, " accept"}, 32'(n_acc - n0), 32'd1);
  endtask

  task automatic wait_done(input int target, input int bound);
    int k = 0;
    while (done_cnt < target && k < bound) begin
      step(1);
      k++;
    end
  endtask

  task automatic run_note(input string tag, input int h, input int d, input int t,
                          input int lat, input int act, input int rise_exp);
    int n0;
    ticks_per_milli  = 16'(t);
    note_half_period = 16'(h);
    note_duration    = DW'(d);
    act_cnt  = 0;
    rises    = 0;
    done_cnt = 0;
    n0 = n_acc;
    note_valid = 1'b1;
    wait_accept(tag, n0);
    note_valid = 1'b0;
    wait_done(1, lat + 50);
    step(3);
    chk({tag, " done count"}, 32'(done_cnt), 32'd1);
    chk({tag, " latency"}, 32'(done_at - acc_cyc), 32'(lat));
    chk({tag, " play cycles"}, 32'(act_cnt), 32'(act));
    chk({tag, " sound rises"}, 32'(rises), 32'(rise_exp));
  endtask

  int a1, n0;

  initial begin
    ticks_per_milli = 16'd100;
    step(2);
    chk("reset sound", 32'(sound), 32'd0);
    chk("reset active", 32'(note_active), 32'd0);
    chk("reset done", 32'(note_done), 32'd0);
    chk("reset ready", 32'(note_ready), 32'd1);
    rst_n = 1'b1;
    #1 chk("ready after reset", 32'(note_ready), 32'd1);
    step(2);

    run_note("tone50", 50, 3, 100, 1300, 300, 3);
    run_note("rest", 0, 2, 100, 1200, 200, 0);
    run_note("zero dur", 7, 0, 0, 10, 0, 0);
    run_note("half1", 1, 2, 3, 36, 6, 3);

    // stop in the middle of PLAY, then stop racing note_valid in IDLE
    ticks_per_milli = 16'd100; note_half_period = 16'd50; note_duration = DW'(3);
    done_cnt = 0;
    n0 = n_acc;
    note_valid = 1'b1;
    wait_accept("stop", n0);
    note_valid = 1'b0;
    step(150);
    chk("stop pre sound", 32'(sound), 32'd1);
    stop = 1'b1;
    step(1);
    chk("stop active", 32'(note_active), 32'd0);
    chk("stop sound", 32'(sound), 32'd0);
    chk("stop ready", 32'(note_ready), 32'd0);
    note_valid = 1'b1;
    step(3);
    stop = 1'b0;
    note_valid = 1'b0;
    #1 chk("ready after stop", 32'(note_ready), 32'd1);
    step(2);
    chk("stop beats valid", 32'(note_active), 32'd0);
    step(1200);
    chk("stop no done", 32'(done_cnt), 32'd0);

    // asynchronous reset while sound is high
    n0 = n_acc;
    note_valid = 1'b1;
    wait_accept("reset", n0);
    note_valid = 1'b0;
    step(60);
    chk("pre reset sound", 32'(sound), 32'd1);
    done_cnt = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async reset sound", 32'(sound), 32'd0);
    chk("async reset active", 32'(note_active), 32'd0);
    step(2);
    rst_n = 1'b1;
    #1 chk("ready after mid reset", 32'(note_ready), 32'd1);
    step(30);
    chk("reset no done", 32'(done_cnt), 32'd0);

    // back-to-back notes with note_valid held high
    ticks_per_milli = 16'd4; note_half_period = 16'd3; note_duration = DW'(2);
    done_cnt = 0;
    n0 = n_acc;
    note_valid = 1'b1;
    wait_accept("b2b first", n0);
    a1 = acc_cyc;
    note_half_period = 16'd1; note_duration = DW'(1);
    n0 = n_acc;
    begin
      int k = 0;
      while (n_acc == n0 && k < 200) begin
        step(1);
        k++;
      end
    end
    chk("b2b second accept", 32'(n_acc - n0), 32'd1);
    note_valid = 1'b0;
    chk("b2b first latency", 32'(done_at - a1), 32'd48);
    chk("b2b accept after done", 32'(acc_cyc - done_at), 32'd1);
    wait_done(2, 150);
    step(2);
    chk("b2b done count", 32'(done_cnt), 32'd2);
    chk("b2b second latency", 32'(done_at - acc_cyc), 32'd44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
